fb_cell_mem: RTL
================

# fb_cell_mem

Cell memory and arbiter for the extended text-mode framebuffer. It holds the 128-bit display cells that the text/graphics pixel pipeline indexes by cell number. It returns a registered `cellData` word one cycle after a new `pixCellIx`. It also exposes a 32-bit request/acknowledge bus port so the CPU can write (and optionally read back) cell contents. A single-ported RAM is shared between the two ports. The display has priority, with a bounded-wait guard for the bus.

## Interface
- `CELL_AW`, 10, cell address width; the block holds 2^CELL_AW cells of 128 bits.
- `BUS_WAIT_MAX`, 15, maximum consecutive cycles the bus may lose arbitration before it is forced through.

- `clock`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pixCellIx`  in  14  cell index requested by the display pipeline.
- `cellData`  out  128  cell contents for the last fetched index.
- `busReq`  in  1  bus request; held high until `busOk` is seen.
- `busWr`  in  1  1 = write, 0 = read; stable while `busReq` is high.
- `busAddr`  in  CELL_AW+4  byte address. [CELL_AW+3:4] selects the cell, [3:2] selects the 32-bit lane, [1:0] is ignored.
- `busMask`  in  4  byte enables for writes; bit i enables byte i of the lane.
- `busWdata`  in  32  write data.
- `busRdata`  out  32  read data, valid while `busOk` is high.
- `busOk`  out  1  acknowledge.

## Operation
- Lane mapping: lane 0 = `cellData`[31:0], lane 1 = [63:32], lane 2 = [95:64], lane 3 = [127:96].
- `lastIx` register: the index whose contents are currently on `cellData`.
- Display port:
  - The display needs the RAM when `pixCellIx` != `lastIx`.
  - A fetch reads the RAM, loads `cellData` at the next edge, and sets `lastIx` = `pixCellIx`.
  - If `pixCellIx` >= 2^CELL_AW, no RAM access occurs, `cellData` loads 0, and `lastIx` updates.
- Bus FSM has three states: IDLE, WAIT, ACK.
  - IDLE, `busReq`=0: stay in IDLE.
  - IDLE or WAIT, `busReq`=1, and either the display does not need the RAM or the guard fires: perform the access and go to ACK.
  - IDLE or WAIT, `busReq`=1, display needs the RAM and the guard does not fire: go to (or stay in) WAIT and increment `waitCnt`.
  - ACK: `busOk`=1 and `busRdata` is held. When `busReq`=0, go to IDLE and `busOk` drops.
- Guard: fires when `waitCnt` == BUS_WAIT_MAX.
  - The bus takes the RAM that cycle and the display fetch is deferred one cycle; `cellData` keeps its old value for that cycle.
  - `waitCnt` clears whenever an access is performed.
- Write: read-modify-write within the selected lane; only the bytes enabled by `busMask` change.
  - If the written cell == `lastIx`, `lastIx` is set to all-ones so the display refetches on the next cycle it can.
- Read: `busRdata` is loaded with the selected lane.
- Bus addresses are always in range, since the cell field is exactly CELL_AW bits wide.
- Memory contents are not reset.

## Timing
- Reset values: `cellData`=0, `busRdata`=0, `busOk`=0, state=IDLE, `waitCnt`=0, `lastIx`=all-ones.
- `reset` low mid-transaction aborts it. A write committed at an earlier edge persists; `busOk` goes low immediately.
- Display latency:
  - `pixCellIx` changes before edge N → `cellData` valid after edge N.
  - If the guard fired at edge N, `cellData` is valid after edge N+1.
- Bus latency:
  - With no display conflict, `busReq` is sampled at edge N, the access commits at edge N, and `busOk` is high after edge N.
  - The worst case is BUS_WAIT_MAX+1 edges.
- `busOk` stays high until the edge after `busReq` is sampled low.
- A new request can be accepted no earlier than the edge after that.
- Simultaneous display need and bus request at the guard threshold: the bus wins. Otherwise the display always wins.

## Configuration
- `FBCELL_READBACK_EN`
  - Defined: bus reads return lane data as described above.
  - Undefined:
    - Reads do not occupy the RAM. They go from IDLE to ACK on the first sampled edge regardless of the display, with `busRdata`=0.
    - No read path is implemented; writes are unchanged.

## Test plan
- Write cell 5, lane 2, `busWdata`=0x12345678, mask 0xF; then set `pixCellIx`=5 → one cycle later `cellData`[95:64]=0x12345678 and all other lanes keep their prior contents.
- Write to cell 5, lane 0, mask 0x2, data 0xAABBCCDD while `lastIx`=5 → display refetches; `cellData`[15:8]=0xCC and the other bytes are unchanged.
- `pixCellIx` changes every cycle while `busReq` is held → `busOk` rises exactly 16 edges after `busReq` is first sampled high (BUS_WAIT_MAX=15); `cellData` lags one extra cycle on that edge.
- `pixCellIx`=1500 with CELL_AW=10 → `cellData`=0 after one cycle; the RAM is not accessed and a pending bus request completes in that same cycle.
- Read-back of cell 5, lane 2 → `busRdata`=0x12345678 while `busOk`=1. With `FBCELL_READBACK_EN` undefined, `busRdata`=0 and `busOk` rises after the first edge.
- `reset` asserted low while the FSM is in ACK → `busOk`, `cellData` and `busRdata` read 0 immediately. After release, `pixCellIx`=5 refetches because `lastIx` is all-ones.

Source files
------------

// File: rtl/fb_cell_mem_if.sv
// CPU-side request/acknowledge bus into the framebuffer cell memory.
// busAddr carries the cell in [CELL_AW+3:4] and the 32-bit lane in [3:2].
interface fb_cell_mem_if #(
    parameter int CELL_AW = 10
);
    logic               busReq;
    logic               busWr;
    logic [CELL_AW+3:0] busAddr;
    logic [3:0]         busMask;
    logic [31:0]        busWdata;
    logic [31:0]        busRdata;
    logic               busOk;

    modport master (
        output busReq, busWr, busAddr, busMask, busWdata,
        input  busRdata, busOk
    );

    modport slave (
        input  busReq, busWr, busAddr, busMask, busWdata,
        output busRdata, busOk
    );
endinterface

// File: rtl/fb_cell_mem.sv
// Framebuffer cell memory shared by the display fetch and the CPU bus; display has priority.
// Define FBCELL_READBACK_EN to give bus reads a real RAM read path (otherwise reads return 0).
module fb_cell_mem #(
    parameter int CELL_AW      = 10,
    parameter int BUS_WAIT_MAX = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [13:0]   pixCellIx,
    output logic [127:0]  cellData,
    fb_cell_mem_if.slave  bus
);
    localparam int          WCNT_W  = $clog2(BUS_WAIT_MAX + 1);
    localparam logic [13:0] IX_NONE = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} busState_t;

    logic [127:0]       mem [2**CELL_AW];
    busState_t          state, stateNext;
    logic [WCNT_W-1:0]  waitCnt;
    logic [13:0]        lastIx;

    logic [CELL_AW-1:0] busCell;
    logic [1:0]         busLane;
    logic [CELL_AW-1:0] pixIx;
    logic               unusedAddrBits;

    logic               pixInRange, dispNeed, dispRamNeed, guardFire;
    logic               busPending, readNoRam, busGrant, busRamUse;
    logic               dispFetch, wrHitsDisplay;
    logic [127:0]       busWord, rmwWord;
    logic [31:0]        rmwLane;

    assign busCell        = bus.busAddr[CELL_AW+3:4];
    assign busLane        = bus.busAddr[3:2];
    assign pixIx          = pixCellIx[CELL_AW-1:0];
    assign unusedAddrBits = ^bus.busAddr[1:0];

    // Out-of-range display indices resolve to zero without touching the RAM,
    // so they never block the bus.
    always_comb begin
        pixInRange  = (32'(pixCellIx) >> CELL_AW) == 32'd0;
        dispNeed    = pixCellIx != lastIx;
        dispRamNeed = dispNeed && pixInRange;
        guardFire   = waitCnt == WCNT_W'(BUS_WAIT_MAX);
        busPending  = bus.busReq && (state != S_ACK);
`ifdef FBCELL_READBACK_EN
        readNoRam   = 1'b0;
`else
        readNoRam   = !bus.busWr;
`endif
        busGrant      = busPending && (readNoRam || !dispRamNeed || guardFire);
        busRamUse     = busGrant && !readNoRam;
        dispFetch     = dispNeed && !(busRamUse && dispRamNeed);
        wrHitsDisplay = busGrant && bus.busWr && (14'(busCell) == lastIx);
    end

    always_comb begin
        busWord = mem[busCell];
        rmwLane = busWord[{busLane, 5'd0} +: 32];
        for (int unsigned b = 0; b < 4; b++) begin
            if (bus.busMask[b]) rmwLane[8*b +: 8] = bus.busWdata[8*b +: 8];
        end
        rmwWord = busWord;
        rmwWord[{busLane, 5'd0} +: 32] = rmwLane;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            waitCnt <= '0;
        end else begin
            state <= stateNext;
            if (busGrant || !busPending) waitCnt <= '0;
            else                         waitCnt <= waitCnt + 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            S_IDLE, S_WAIT: begin
                if (!bus.busReq)  stateNext = S_IDLE;
                else if (busGrant) stateNext = S_ACK;
                else               stateNext = S_WAIT;
            end
            S_ACK:   if (!bus.busReq) stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busOk = (state == S_ACK);
    end

    // A write into the displayed cell invalidates lastIx so the display refetches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cellData <= '0;
            lastIx   <= IX_NONE;
        end else if (dispFetch) begin
            cellData <= pixInRange ? mem[pixIx] : '0;
            lastIx   <= pixCellIx;
        end else if (wrHitsDisplay) begin
            lastIx   <= IX_NONE;
        end
    end

    always_ff @(posedge clock) begin
        if (busRamUse && bus.busWr) mem[busCell] <= rmwWord;
    end

`ifdef FBCELL_READBACK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       bus.busRdata <= '0;
        else if (busRamUse && !bus.busWr) bus.busRdata <= busWord[{busLane, 5'd0} +: 32];
    end
`else
    assign bus.busRdata = '0;
`endif
endmodule
